// File: rtl/edge_stream_packer.sv
// Tags the sobel edge-pixel stream with frame position markers and buffers it
// in a first-word-fall-through FIFO behind a ready/valid port; also counts edges per frame.
module edge_stream_packer #(
    parameter int IMG_W      = 640,
    parameter int IMG_H      = 480,
    parameter int FIFO_DEPTH = 16,
    parameter int CNT_W      = 19
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       data_i,
    input  logic             valid_i,
    output logic [7:0]       data_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic             sof_o,
    output logic             eol_o,
    output logic             eof_o,
    output logic [CNT_W-1:0] edge_cnt_o,
    output logic             edge_cnt_valid_o,
    output logic             overflow_o
);

    localparam int XW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int YW = (IMG_H > 1) ? $clog2(IMG_H) : 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int OW = $clog2(FIFO_DEPTH + 1);

    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    localparam logic [OW-1:0] OCC_FULL = OW'(FIFO_DEPTH);

    typedef struct packed {
        logic       sof;
        logic       eol;
        logic       eof;
        logic [7:0] data;
    } entry_t;

    logic [XW-1:0]    x_q, x_d;
    logic [YW-1:0]    y_q, y_d;
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]    occ_q, occ_d;
    logic [CNT_W-1:0] run_cnt_q, run_cnt_d;
    logic [CNT_W-1:0] edge_cnt_q, edge_cnt_d;
    logic             edge_cnt_valid_q, edge_cnt_valid_d;
    logic             overflow_q, overflow_d;

    entry_t mem_q [FIFO_DEPTH];
    entry_t in_entry;
    entry_t head;

    logic fifo_empty;
    logic fifo_full;
    logic push;
    logic pop;
    logic pixel_nz;

    // Tags come from the position of the pixel arriving this cycle.
    always_comb begin
        in_entry.sof  = (x_q == '0) && (y_q == '0);
        in_entry.eol  = (x_q == X_LAST);
        in_entry.eof  = (x_q == X_LAST) && (y_q == Y_LAST);
        in_entry.data = data_i;
    end

    assign fifo_empty = (occ_q == '0);
    assign fifo_full  = (occ_q == OCC_FULL);
    assign pop        = !fifo_empty && ready_i;
    assign push       = valid_i && (!fifo_full || pop);
    assign pixel_nz   = (data_i != 8'd0);

    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (valid_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + 1'b1;
            end else begin
                x_d = x_q + 1'b1;
            end
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push, pop})
            2'b10:   occ_d = occ_q + 1'b1;
            2'b01:   occ_d = occ_q - 1'b1;
            default: occ_d = occ_q;
        endcase
    end

    // Dropped pixels still count toward the frame total.
    always_comb begin
        run_cnt_d        = run_cnt_q;
        edge_cnt_d       = edge_cnt_q;
        edge_cnt_valid_d = 1'b0;
        overflow_d       = overflow_q | (valid_i & ~push);
        if (valid_i) begin
            if (in_entry.eof) begin
                edge_cnt_d       = run_cnt_q + CNT_W'(pixel_nz);
                edge_cnt_valid_d = 1'b1;
                run_cnt_d        = '0;
            end else begin
                run_cnt_d = run_cnt_q + CNT_W'(pixel_nz);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q              <= '0;
            y_q              <= '0;
            wr_ptr_q         <= '0;
            rd_ptr_q         <= '0;
            occ_q            <= '0;
            run_cnt_q        <= '0;
            edge_cnt_q       <= '0;
            edge_cnt_valid_q <= 1'b0;
            overflow_q       <= 1'b0;
        end else begin
            x_q              <= x_d;
            y_q              <= y_d;
            wr_ptr_q         <= wr_ptr_d;
            rd_ptr_q         <= rd_ptr_d;
            occ_q            <= occ_d;
            run_cnt_q        <= run_cnt_d;
            edge_cnt_q       <= edge_cnt_d;
            edge_cnt_valid_q <= edge_cnt_valid_d;
            overflow_q       <= overflow_d;
        end
    end

    // Storage needs no reset; the pointers and occupancy define what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_entry;
        end
    end

    assign head = mem_q[rd_ptr_q];

    always_comb begin
        valid_o = !fifo_empty;
        data_o  = valid_o ? head.data : 8'd0;
        sof_o   = valid_o && head.sof;
        eol_o   = valid_o && head.eol;
        eof_o   = valid_o && head.eof;
    end

    assign edge_cnt_o       = edge_cnt_q;
    assign edge_cnt_valid_o = edge_cnt_valid_q;
    assign overflow_o       = overflow_q;

endmodule

// File: tb/tb_edge_stream_packer.sv
// Randomized bench for edge_stream_packer on a small frame geometry, checked
// against a queue-based model driven by a global pixel index.
module tb_edge_stream_packer;

    localparam int W  = 5;
    localparam int H  = 3;
    localparam int D  = 16;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [7:0]    data_i;
    logic          valid_i;
    logic          ready_i;
    logic [7:0]    data_o;
    logic          valid_o;
    logic          sof_o;
    logic          eol_o;
    logic          eof_o;
    logic [CW-1:0] edge_cnt_o;
    logic          edge_cnt_valid_o;
    logic          overflow_o;

    int checks   = 0;
    int failures = 0;

    edge_stream_packer #(
        .IMG_W(W), .IMG_H(H), .FIFO_DEPTH(D), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .data_i(data_i), .valid_i(valid_i),
        .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i),
        .sof_o(sof_o), .eol_o(eol_o), .eof_o(eof_o),
        .edge_cnt_o(edge_cnt_o), .edge_cnt_valid_o(edge_cnt_valid_o),
        .overflow_o(overflow_o)
    );

    always #5 clk = ~clk;

    // Model: entries are {sof, eol, eof, data}; position is derived from a pixel index.
    logic [10:0] q[$];
    int          k;
    int          run;
    int          m_cnt;
    bit          m_cv;
    bit          m_ovf;

    logic [11:0]   obs_head, exp_head;
    logic [CW+1:0] obs_stat, exp_stat;
    bit            obs_pop;

    task automatic model_reset();
        q.delete();
        k     = 0;
        run   = 0;
        m_cnt = 0;
        m_cv  = 0;
        m_ovf = 0;
    endtask

    // Called at a falling edge: samples DUT and model, drives inputs, advances model, waits one cycle.
    task automatic cyc(input bit vin, input logic [7:0] din, input bit rdy);
        int x, y;
        logic [10:0] e;
        bit pop, ok, nz;
        obs_head = {valid_o, sof_o, eol_o, eof_o, data_o};
        obs_stat = {overflow_o, edge_cnt_valid_o, edge_cnt_o};
        exp_head = (q.size() != 0) ? {1'b1, q[0]} : 12'h000;
        exp_stat = {m_ovf, m_cv, CW'(m_cnt)};
        obs_pop  = valid_o && rdy;
        valid_i = vin;
        data_i  = din;
        ready_i = rdy;
        pop  = (q.size() != 0) && rdy;
        m_cv = 0;
        ok   = 0;
        e    = '0;
        if (vin) begin
            x  = k % W;
            y  = k / W;
            e  = {1'(x == 0 && y == 0), 1'(x == W - 1), 1'(x == W - 1 && y == H - 1), din};
            ok = (q.size() < D) || pop;
            nz = (din != 8'd0);
            if (x == W - 1 && y == H - 1) begin
                m_cnt = run + int'(nz);
                m_cv  = 1;
                run   = 0;
            end else begin
                run = run + int'(nz);
            end
            k = (k + 1) % (W * H);
        end
        if (pop) void'(q.pop_front());
        if (vin) begin
            if (ok) q.push_back(e);
            else m_ovf = 1;
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'd0;
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({valid_o, sof_o, eol_o, eof_o, data_o, edge_cnt_o, edge_cnt_valid_o, overflow_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs got v=%b s=%b l=%b f=%b d=%h cnt=%h cv=%b ovf=%b required all zero",
                     valid_o, sof_o, eol_o, eof_o, data_o, edge_cnt_o, edge_cnt_valid_o, overflow_o);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_basic_frame();
        int pulses = 0;
        int outs   = 0;
        for (int i = 1; i <= W * H + 4; i++) begin
            if (i <= W * H) cyc(1'b1, 8'(i), 1'b1);
            else cyc(1'b0, 8'd0, 1'b1);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL basic_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            if (obs_stat !== exp_stat) begin
                failures++;
                $display("FAIL basic_status i=%0d got=%h required=%h", i, obs_stat, exp_stat);
            end
            checks += 2;
            pulses += int'(obs_stat[CW]);
            outs   += int'(obs_pop);
        end
        checks += 2;
        if (pulses != 1 || edge_cnt_o !== CW'(W * H)) begin
            failures++;
            $display("FAIL basic_edge_count pulses=%0d cnt=%0d required pulses=1 cnt=%0d", pulses, edge_cnt_o, W * H);
        end
        if (outs != W * H) begin
            failures++;
            $display("FAIL basic_output_count got=%0d required=%0d", outs, W * H);
        end
    endtask

    task automatic test_overflow();
        int outs = 0;
        for (int i = 0; i < 20 + 24; i++) begin
            if (i < 20) cyc(1'b1, 8'($urandom_range(1, 255)), 1'b0);
            else cyc(1'b0, 8'd0, 1'b1);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL ovf_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            if (obs_stat !== exp_stat) begin
                failures++;
                $display("FAIL ovf_status i=%0d got=%h required=%h", i, obs_stat, exp_stat);
            end
            checks += 2;
            outs += int'(obs_pop);
        end
        checks++;
        if (outs != D || overflow_o !== 1'b1) begin
            failures++;
            $display("FAIL ovf_drain outs=%0d ovf=%b required outs=%0d ovf=1", outs, overflow_o, D);
        end
    endtask

    task automatic test_full_push_pop();
        int outs = 0;
        for (int i = 0; i < D + 1 + 20; i++) begin
            if (i < D) cyc(1'b1, 8'($urandom_range(0, 255)), 1'b0);
            else if (i == D) cyc(1'b1, 8'hA5, 1'b1);
            else cyc(1'b0, 8'd0, 1'b1);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL fullpp_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            if (obs_stat !== exp_stat) begin
                failures++;
                $display("FAIL fullpp_status i=%0d got=%h required=%h", i, obs_stat, exp_stat);
            end
            checks += 2;
            if (i > D) outs += int'(obs_pop);
        end
        checks++;
        if (outs != D || overflow_o !== 1'b0) begin
            failures++;
            $display("FAIL fullpp_drain outs=%0d ovf=%b required outs=%0d ovf=0", outs, overflow_o, D);
        end
    endtask

    task automatic test_random();
        int pixels = 0;
        int pulses = 0;
        bit vin;
        for (int i = 0; i < 3000 && (pixels < 3 * W * H || q.size() != 0 || i < 3 * W * H + 8); i++) begin
            vin = (pixels < 3 * W * H) && ($urandom_range(0, 99) < 35);
            cyc(vin, ($urandom_range(0, 1) == 1) ? 8'($urandom_range(1, 255)) : 8'd0, 1'($urandom_range(0, 1)));
            pixels += int'(vin);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL rand_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            if (obs_stat !== exp_stat) begin
                failures++;
                $display("FAIL rand_status i=%0d got=%h required=%h", i, obs_stat, exp_stat);
            end
            checks += 2;
            pulses += int'(obs_stat[CW]);
        end
        cyc(1'b0, 8'd0, 1'b1);
        pulses += int'(obs_stat[CW]);
        checks++;
        if (pulses != 3 || pixels != 3 * W * H) begin
            failures++;
            $display("FAIL rand_frames pulses=%0d pixels=%0d required pulses=3 pixels=%0d", pulses, pixels, 3 * W * H);
        end
    endtask

    task automatic test_mid_reset();
        int nz = 0;
        logic [7:0] d;
        for (int i = 0; i < W + 3; i++) begin
            cyc(1'b1, 8'($urandom_range(1, 255)), 1'b0);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL midrst_fill_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            checks++;
        end
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        @(negedge clk);
        checks++;
        if (valid_o !== 1'b0) begin
            failures++;
            $display("FAIL midrst_valid got=%b required=0", valid_o);
        end
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < W * H + 4; i++) begin
            d = (i < W * H && $urandom_range(0, 2) != 0) ? 8'($urandom_range(1, 255)) : 8'd0;
            if (i < W * H) nz += int'(d != 8'd0);
            cyc(i < W * H, d, 1'b1);
            if (obs_head[11] !== exp_head[11] || (exp_head[11] && obs_head !== exp_head)) begin
                failures++;
                $display("FAIL midrst_head i=%0d got=%h required=%h", i, obs_head, exp_head);
            end
            if (obs_stat !== exp_stat) begin
                failures++;
                $display("FAIL midrst_status i=%0d got=%h required=%h", i, obs_stat, exp_stat);
            end
            checks += 2;
        end
        checks++;
        if (edge_cnt_o !== CW'(nz)) begin
            failures++;
            $display("FAIL midrst_edge_count got=%0d required=%0d", edge_cnt_o, nz);
        end
    endtask

    initial begin
        rst     = 1'b1;
        valid_i = 1'b0;
        ready_i = 1'b0;
        data_i  = 8'd0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_basic_frame();
        test_reset();
        test_overflow();
        test_reset();
        test_full_push_pop();
        test_reset();
        test_random();
        test_reset();
        test_mid_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout simulation did not finish within time limit");
        failures++;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule
